bfly12: RTL and testbench

BFLY12 -- requirements
Module: bfly12

---
 rtl/bfly12_pkg.sv | 14 +
 rtl/bfly12_counter.sv | 26 ++
 rtl/bfly12.sv | 119 +++++++++++
 tb/tb_bfly12.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfly12_pkg.sv
// Shared FFT package: lane geometry and default widths for the butterfly stages.
package bfly12_pkg;

  localparam int unsigned FFT_WIDTH   = 15;  // signed input lane width, 6 fractional bits
  localparam int unsigned FFT_CLK_CNT = 4;   // valid beats per frame
  localparam int unsigned FFT_LANES   = 16;  // lanes per data array
  localparam int unsigned FFT_ARRAYS  = 4;   // sum_re, sum_im, diff_re, diff_im

  // Index width for a beat counter; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bfly12_counter.sv
// Enabled modulo counter: counts 0..COUNT_MAX_VAL, advancing only when en is high.
module bfly12_counter #(
  parameter int unsigned COUNT_MAX_VAL = 3,
  parameter int unsigned CNT_W         = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Advance on enable, wrapping back to zero after the terminal value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (en) begin
      if (r_count == CNT_W'(COUNT_MAX_VAL)) r_count <= '0;
      else                                  r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/bfly12.sv
// Radix-2 butterfly across lane pairs (n, n+4) of four data arrays, two register stages,
// with frame beat index and start/end-of-frame flags travelling alongside the data.
module bfly12
  import bfly12_pkg::*;
#(
  parameter int unsigned WIDTH   = FFT_WIDTH,
  parameter int unsigned CLK_CNT = FFT_CLK_CNT
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                bfly12_valid,
  input  logic signed [WIDTH-1:0]             i_sum_re  [0:FFT_LANES-1],
  input  logic signed [WIDTH-1:0]             i_sum_im  [0:FFT_LANES-1],
  input  logic signed [WIDTH-1:0]             i_diff_re [0:FFT_LANES-1],
  input  logic signed [WIDTH-1:0]             i_diff_im [0:FFT_LANES-1],
  output logic signed [WIDTH:0]               o_sum_re  [0:FFT_LANES-1],
  output logic signed [WIDTH:0]               o_sum_im  [0:FFT_LANES-1],
  output logic signed [WIDTH:0]               o_diff_re [0:FFT_LANES-1],
  output logic signed [WIDTH:0]               o_diff_im [0:FFT_LANES-1],
  output logic                                o_bfly12_valid,
  output logic [idx_width(CLK_CNT)-1:0]       o_blk_idx,
  output logic                                o_sop,
  output logic                                o_eop
);

  localparam int unsigned IDX_W = idx_width(CLK_CNT);

  logic signed [WIDTH-1:0] w_in   [FFT_ARRAYS][FFT_LANES];
  logic signed [WIDTH-1:0] r_s1   [FFT_ARRAYS][FFT_LANES];
  logic signed [WIDTH:0]   w_bf   [FFT_ARRAYS][FFT_LANES];
  logic signed [WIDTH:0]   r_s2   [FFT_ARRAYS][FFT_LANES];
  logic                    r_s1_valid, r_s2_valid;
  logic [IDX_W-1:0]        r_s1_idx, r_s2_idx;
  logic [IDX_W-1:0]        w_beat;

  // Beat position of the incoming beat; advances only on accepted beats.
  bfly12_counter #(
    .COUNT_MAX_VAL (CLK_CNT - 1),
    .CNT_W         (IDX_W)
  ) u_beat_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .en    (bfly12_valid),
    .count (w_beat)
  );

  // Gather the four input arrays into one indexable array.
  always_comb begin
    for (int n = 0; n < FFT_LANES; n++) begin
      w_in[0][n] = i_sum_re[n];
      w_in[1][n] = i_sum_im[n];
      w_in[2][n] = i_diff_re[n];
      w_in[3][n] = i_diff_im[n];
    end
  end

  // Stage 1: capture input lanes and beat index on valid; hold otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      for (int a = 0; a < FFT_ARRAYS; a++)
        for (int n = 0; n < FFT_LANES; n++) r_s1[a][n] <= '0;
    end else begin
      r_s1_valid <= bfly12_valid;
      if (bfly12_valid) begin
        r_s1_idx <= w_beat;
        for (int a = 0; a < FFT_ARRAYS; a++)
          for (int n = 0; n < FFT_LANES; n++) r_s1[a][n] <= w_in[a][n];
      end
    end
  end

  // Full-precision butterfly: lanes n with (n mod 8) < 4 pair with lane n+4.
  for (genvar a = 0; a < FFT_ARRAYS; a++) begin : g_arr
    for (genvar n = 0; n < FFT_LANES; n++) begin : g_lane
      if ((n % 8) < 4) begin : g_bf
        logic signed [WIDTH:0] w_a, w_b;
        assign w_a           = {r_s1[a][n][WIDTH-1], r_s1[a][n]};
        assign w_b           = {r_s1[a][n+4][WIDTH-1], r_s1[a][n+4]};
        assign w_bf[a][n]    = w_a + w_b;
        assign w_bf[a][n+4]  = w_a - w_b;
      end
    end
  end

  // Stage 2: register butterfly results and index when stage 1 holds a valid beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s2_valid <= 1'b0;
      r_s2_idx   <= '0;
      for (int a = 0; a < FFT_ARRAYS; a++)
        for (int n = 0; n < FFT_LANES; n++) r_s2[a][n] <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_idx <= r_s1_idx;
        for (int a = 0; a < FFT_ARRAYS; a++)
          for (int n = 0; n < FFT_LANES; n++) r_s2[a][n] <= w_bf[a][n];
      end
    end
  end

  // Scatter stage-2 results onto the output arrays.
  always_comb begin
    for (int n = 0; n < FFT_LANES; n++) begin
      o_sum_re[n]  = r_s2[0][n];
      o_sum_im[n]  = r_s2[1][n];
      o_diff_re[n] = r_s2[2][n];
      o_diff_im[n] = r_s2[3][n];
    end
  end

  assign o_bfly12_valid = r_s2_valid;
  assign o_blk_idx      = r_s2_idx;
  assign o_sop          = r_s2_valid & (r_s2_idx == '0);
  assign o_eop          = r_s2_valid & (r_s2_idx == IDX_W'(CLK_CNT - 1));

endmodule

// File: tb/tb_bfly12.sv
// Self-checking bench for bfly12: queue-based reference model plus directed literal checks.
module tb_bfly12;

  localparam int CC = 4;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic bfly12_valid = 1'b0;
  logic signed [14:0] i_sum_re [0:15];
  logic signed [14:0] i_sum_im [0:15];
  logic signed [14:0] i_diff_re [0:15];
  logic signed [14:0] i_diff_im [0:15];
  logic signed [15:0] o_sum_re [0:15];
  logic signed [15:0] o_sum_im [0:15];
  logic signed [15:0] o_diff_re [0:15];
  logic signed [15:0] o_diff_im [0:15];
  logic               o_bfly12_valid;
  logic [1:0]         o_blk_idx;
  logic               o_sop, o_eop;

  bfly12 dut (
    .clk            (clk),
    .rstn           (rstn),
    .bfly12_valid   (bfly12_valid),
    .i_sum_re       (i_sum_re),
    .i_sum_im       (i_sum_im),
    .i_diff_re      (i_diff_re),
    .i_diff_im      (i_diff_im),
    .o_sum_re       (o_sum_re),
    .o_sum_im       (o_sum_im),
    .o_diff_re      (o_diff_re),
    .o_diff_im      (o_diff_im),
    .o_bfly12_valid (o_bfly12_valid),
    .o_blk_idx      (o_blk_idx),
    .o_sop          (o_sop),
    .o_eop          (o_eop)
  );

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int m_beat = 0;
  int g [4][16];
  int q_due [$];
  int q_idx [$];
  int q_val [$];
  int obs_idx [$];
  int obs_cyc [$];
  int obs_sop [$];
  int obs_eop [$];
  bit log_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference butterfly straight from the pairing rule.
  function automatic int model(input int a, input int n);
    if ((n % 8) < 4) return g[a][n] + g[a][n+4];
    else             return g[a][n-4] - g[a][n];
  endfunction

  function automatic int dut_out(input int a, input int n);
    case (a)
      0:       return o_sum_re[n];
      1:       return o_sum_im[n];
      2:       return o_diff_re[n];
      default: return o_diff_im[n];
    endcase
  endfunction

  task automatic set_in(input int a, input int n, input int v);
    case (a)
      0:       i_sum_re[n]  = 15'(v);
      1:       i_sum_im[n]  = 15'(v);
      2:       i_diff_re[n] = 15'(v);
      default: i_diff_im[n] = 15'(v);
    endcase
  endtask

  task automatic fill_g(input int v);
    for (int a = 0; a < 4; a++) for (int n = 0; n < 16; n++) g[a][n] = v;
  endtask

  task automatic rand_g();
    for (int a = 0; a < 4; a++)
      for (int n = 0; n < 16; n++) g[a][n] = int'($urandom_range(32767)) - 16384;
  endtask

  // Drive one cycle; valid beats are queued with the cycle their result must appear.
  task automatic send(input bit v);
    @(negedge clk);
    bfly12_valid = v;
    for (int a = 0; a < 4; a++) for (int n = 0; n < 16; n++) set_in(a, n, g[a][n]);
    if (v) begin
      q_due.push_back(cyc + 2);
      q_idx.push_back(m_beat);
      for (int a = 0; a < 4; a++) for (int n = 0; n < 16; n++) q_val.push_back(model(a, n));
      m_beat = (m_beat + 1) % CC;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, o_bfly12_valid, 0);
    chk({tag, "_idx"}, o_blk_idx, 0);
    chk({tag, "_sop"}, o_sop, 0);
    chk({tag, "_eop"}, o_eop, 0);
    for (int a = 0; a < 4; a++)
      for (int n = 0; n < 16; n++) chk($sformatf("%s_lane a%0d n%0d", tag, a, n), dut_out(a, n), 0);
  endtask

  // Async reset pulse mid-cycle; in-flight beats are dropped from the model.
  task automatic do_reset();
    @(negedge clk);
    bfly12_valid = 1'b0;
    #2 rstn = 1'b0;
    #1 check_zero_outputs("rst");
    q_due.delete();
    q_idx.delete();
    q_val.delete();
    m_beat = 0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Per-cycle compare against the model queue.
  always @(posedge clk) begin
    bit ev;
    int idx;
    #1;
    if (rstn) begin
      ev = (q_due.size() > 0) && (q_due[0] == cyc);
      chk("valid", o_bfly12_valid, ev);
      if (ev) begin
        void'(q_due.pop_front());
        idx = q_idx.pop_front();
        chk("blk_idx", o_blk_idx, idx);
        chk("sop", o_sop, idx == 0);
        chk("eop", o_eop, idx == CC - 1);
        for (int a = 0; a < 4; a++)
          for (int n = 0; n < 16; n++)
            chk($sformatf("lane a%0d n%0d", a, n), dut_out(a, n), q_val.pop_front());
      end
      if (log_en && o_bfly12_valid) begin
        obs_idx.push_back(o_blk_idx);
        obs_cyc.push_back(cyc);
        obs_sop.push_back(o_sop);
        obs_eop.push_back(o_eop);
      end
    end
  end

  task automatic clear_obs();
    obs_idx.delete();
    obs_cyc.delete();
    obs_sop.delete();
    obs_eop.delete();
  endtask

  initial begin
    int exp_idx[5] = '{0, 1, 2, 3, 0};
    int exp_sop[5] = '{1, 0, 0, 0, 1};
    int exp_eop[5] = '{0, 0, 0, 1, 0};
    fill_g(0);
    for (int a = 0; a < 4; a++) for (int n = 0; n < 16; n++) set_in(a, n, 0);
    #2 rstn = 1'b0;
    #1 check_zero_outputs("init");
    @(negedge clk);
    rstn = 1'b1;

    // Single beat.
    fill_g(0);
    g[0][0] = 100;
    g[0][4] = 30;
    chk("pin_add", model(0, 0), 130);
    chk("pin_sub", model(0, 4), 70);
    send(1'b1);
    send(1'b0);
    @(posedge clk); #2;
    chk("single_sum0", o_sum_re[0], 130);
    chk("single_sum4", o_sum_re[4], 70);
    chk("single_valid", o_bfly12_valid, 1);
    chk("single_sop", o_sop, 1);
    @(posedge clk); #2;
    chk("single_valid_drop", o_bfly12_valid, 0);

    // Extremes: no wrap at the most negative and most positive inputs.
    fill_g(-16384);
    chk("pin_min", model(1, 2), -32768);
    send(1'b1);
    send(1'b0);
    @(posedge clk); #2;
    for (int a = 0; a < 4; a++)
      for (int n = 0; n < 16; n++)
        chk($sformatf("min a%0d n%0d", a, n), dut_out(a, n), ((n % 8) < 4) ? -32768 : 0);
    fill_g(16383);
    chk("pin_max", model(2, 9), 32766);
    send(1'b1);
    send(1'b0);
    @(posedge clk); #2;
    for (int a = 0; a < 4; a++)
      for (int n = 0; n < 16; n++)
        chk($sformatf("max a%0d n%0d", a, n), dut_out(a, n), ((n % 8) < 4) ? 32766 : 0);

    // Back-to-back frames.
    do_reset();
    clear_obs();
    log_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_g();
      send(1'b1);
    end
    send(1'b0);
    repeat (3) @(posedge clk);
    #2 log_en = 1'b0;
    chk("b2b_count", obs_idx.size(), 5);
    if (obs_idx.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("b2b_idx%0d", i), obs_idx[i], exp_idx[i]);
        chk($sformatf("b2b_sop%0d", i), obs_sop[i], exp_sop[i]);
        chk($sformatf("b2b_eop%0d", i), obs_eop[i], exp_eop[i]);
        if (i > 0) chk($sformatf("b2b_gap%0d", i), obs_cyc[i] - obs_cyc[i-1], 1);
      end
    end

    // Gapped valid pattern 1,0,0,1,1.
    do_reset();
    clear_obs();
    log_en = 1'b1;
    rand_g(); send(1'b1);
    send(1'b0);
    send(1'b0);
    rand_g(); send(1'b1);
    rand_g(); send(1'b1);
    send(1'b0);
    repeat (3) @(posedge clk);
    #2 log_en = 1'b0;
    chk("gap_count", obs_idx.size(), 3);
    if (obs_idx.size() == 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("gap_idx%0d", i), obs_idx[i], i);
      chk("gap_space0", obs_cyc[1] - obs_cyc[0], 3);
      chk("gap_space1", obs_cyc[2] - obs_cyc[1], 1);
    end

    // Reset two beats into a frame.
    do_reset();
    rand_g(); send(1'b1);
    rand_g(); send(1'b1);
    do_reset();
    rand_g(); send(1'b1);
    send(1'b0);
    @(posedge clk); #2;
    chk("post_rst_valid", o_bfly12_valid, 1);
    chk("post_rst_idx", o_blk_idx, 0);
    chk("post_rst_sop", o_sop, 1);

    // Random traffic.
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) do_reset();
      rand_g();
      send($urandom_range(3) != 0);
    end
    send(1'b0);
    repeat (4) @(posedge clk);
    #2 chk("drain", q_due.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
